mem_stage: RTL and testbench

//  RV64 memory-access stage, directly downstream of ex_stage. Consumes alu_result (address or ALU value),
//  rs2_data (store data) and funct3; performs loads/stores on a 64-bit data-memory port using a req/gnt/rvalid

---
 rtl/mem_pkg.sv | 48 ++++
 rtl/mem_stage_load_align.sv | 34 +++
 rtl/mem_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the RV64 memory-access stage.
//   state_t        : FSM encoding (IDLE, REQ, WAIT, RESP)
//   F3_*           : funct3 size/sign encodings for loads and stores
//   EXC_*          : exception codes presented on out_exc
//   check_access() : legality check (illegal size, misalignment) for a mem op
package mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   localparam logic [1:0] EXC_NONE     = 2'b00;
   localparam logic [1:0] EXC_MISALIGN = 2'b01;
   localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
   localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

   // Illegal size takes priority over misalignment.
   // Stores have no unsigned variants, so any f3[2]=1 store is illegal.
   function automatic logic [1:0] check_access(input logic       is_store,
                                               input logic [2:0] funct3,
                                               input logic [2:0] offset);
      logic [1:0] exc;
      exc = EXC_NONE;
      if (is_store ? funct3[2] : (funct3 == 3'b111)) begin
         exc = EXC_ILLEGAL;
      end else begin
         case (funct3[1:0])
            2'b01:   if (offset[0] != 1'b0)      exc = EXC_MISALIGN;
            2'b10:   if (offset[1:0] != 2'b00)   exc = EXC_MISALIGN;
            2'b11:   if (offset != 3'b000)       exc = EXC_MISALIGN;
            default: exc = EXC_NONE;
         endcase
      end
      return exc;
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: combinational load-data extraction.
//   rdata  in  64  aligned doubleword from data memory
//   offset in  3   byte lane of the access (address bits [2:0])
//   funct3 in  3   load size/sign encoding
//   result out 64  selected bytes, sign- or zero-extended to 64 bits
module load_align
   import mem_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [2:0]  offset,
   input  logic [2:0]  funct3,
   output logic [63:0] result
);

   logic [63:0] shifted;

   // Move the addressed lane down to bit 0; misaligned accesses never get here.
   assign shifted = rdata >> {offset, 3'b000};

   always_comb begin
      result = '0;
      case (funct3)
         F3_B:    result = {{56{shifted[7]}},  shifted[7:0]};
         F3_H:    result = {{48{shifted[15]}}, shifted[15:0]};
         F3_W:    result = {{32{shifted[31]}}, shifted[31:0]};
         F3_D:    result = shifted;
         F3_BU:   result = {56'd0, shifted[7:0]};
         F3_HU:   result = {48'd0, shifted[15:0]};
         F3_WU:   result = {32'd0, shifted[31:0]};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV64 memory-access stage, one operation in flight.
//   in_*    : op from EX (valid/ready), load/store flags, funct3, address/ALU value, store data, rd
//   out_*   : registered result to WB (valid/ready), rd, reg_write, exception code
//   dmem_*  : req/gnt/rvalid data-memory port, doubleword aligned with byte enables
// Non-mem ops pass through with latency 1 while the FSM stays in IDLE.
module mem_stage
   import mem_pkg::*;
#(
   parameter int XLEN     = 64,
   parameter int MAX_WAIT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_mem_read,
   input  logic            in_mem_write,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_alu_result,
   input  logic [XLEN-1:0] in_store_data,
   input  logic [4:0]      in_rd_addr,
   input  logic            in_reg_write,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [4:0]      out_rd_addr,
   output logic            out_reg_write,
   output logic [1:0]      out_exc,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [7:0]      dmem_be,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata
);

   // Timeout fires in the MAX_WAIT-th cycle spent in REQ/WAIT.
   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

   state_t          state_reg, state_next;
   logic [7:0]      wait_cnt_reg, wait_cnt_next;
   logic [2:0]      op_funct3_reg;
   logic [2:0]      op_offset_reg;
   logic            op_reg_write_reg;

   logic            accept;
   logic            is_mem;
   logic            timeout;
   logic [1:0]      acc_exc;
   logic [XLEN-1:0] store_wdata;
   logic [7:0]      store_be;
   logic [XLEN-1:0] load_data;

   assign in_ready = (state_reg == ST_IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign is_mem   = in_mem_read || in_mem_write;
   assign acc_exc  = check_access(in_mem_write, in_funct3, in_alu_result[2:0]);
   assign timeout  = (wait_cnt_reg == WAIT_LIMIT);

   load_align u_load_align (
      .rdata  (dmem_rdata),
      .offset (op_offset_reg),
      .funct3 (op_funct3_reg),
      .result (load_data)
   );

   // Store data replicated across lanes so the byte enables alone select the target.
   always_comb begin
      store_wdata = '0;
      store_be    = '0;
      case (in_funct3[1:0])
         2'b00: begin
            store_wdata = {8{in_store_data[7:0]}};
            store_be    = 8'h01 << in_alu_result[2:0];
         end
         2'b01: begin
            store_wdata = {4{in_store_data[15:0]}};
            store_be    = 8'h03 << in_alu_result[2:0];
         end
         2'b10: begin
            store_wdata = {2{in_store_data[31:0]}};
            store_be    = 8'h0F << in_alu_result[2:0];
         end
         default: begin
            store_wdata = in_store_data;
            store_be    = 8'hFF;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         wait_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   // Bus response wins over a timeout in the same cycle.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept && is_mem) begin
               state_next = (acc_exc != EXC_NONE) ? ST_RESP : ST_REQ;
            end
         end
         ST_REQ: begin
            if (dmem_gnt) begin
               state_next = (dmem_we || dmem_rvalid) ? ST_RESP : ST_WAIT;
            end else if (timeout) begin
               state_next = ST_RESP;
            end
         end
         ST_WAIT: begin
            if (dmem_rvalid || timeout) begin
               state_next = ST_RESP;
            end
         end
         default: begin
            if (out_ready) begin
               state_next = ST_IDLE;
            end
         end
      endcase
   end

   // Counter runs only while parked in REQ/WAIT and clears on any state change.
   always_comb begin
      wait_cnt_next = '0;
      if ((state_next == state_reg) && ((state_reg == ST_REQ) || (state_reg == ST_WAIT))) begin
         wait_cnt_next = wait_cnt_reg + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid        <= 1'b0;
         out_result       <= '0;
         out_rd_addr      <= '0;
         out_reg_write    <= 1'b0;
         out_exc          <= EXC_NONE;
         dmem_req         <= 1'b0;
         dmem_we          <= 1'b0;
         dmem_addr        <= '0;
         dmem_wdata       <= '0;
         dmem_be          <= '0;
         op_funct3_reg    <= '0;
         op_offset_reg    <= '0;
         op_reg_write_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  out_rd_addr      <= in_rd_addr;
                  op_funct3_reg    <= in_funct3;
                  op_offset_reg    <= in_alu_result[2:0];
                  op_reg_write_reg <= in_reg_write;
                  if (!is_mem) begin
                     out_valid     <= 1'b1;
                     out_result    <= in_alu_result;
                     out_reg_write <= in_reg_write;
                     out_exc       <= EXC_NONE;
                  end else if (acc_exc != EXC_NONE) begin
                     out_valid     <= 1'b1;
                     out_result    <= '0;
                     out_reg_write <= 1'b0;
                     out_exc       <= acc_exc;
                  end else begin
                     out_valid  <= 1'b0;
                     dmem_req   <= 1'b1;
                     dmem_we    <= in_mem_write;
                     dmem_addr  <= {in_alu_result[XLEN-1:3], 3'b000};
                     dmem_wdata <= store_wdata;
                     dmem_be    <= store_be;
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            ST_REQ: begin
               if (dmem_gnt) begin
                  dmem_req <= 1'b0;
                  if (dmem_we) begin
                     out_valid     <= 1'b1;
                     out_result    <= '0;
                     out_reg_write <= 1'b0;
                     out_exc       <= EXC_NONE;
                  end else if (dmem_rvalid) begin
                     out_valid     <= 1'b1;
                     out_result    <= load_data;
                     out_reg_write <= op_reg_write_reg;
                     out_exc       <= EXC_NONE;
                  end
               end else if (timeout) begin
                  dmem_req      <= 1'b0;
                  out_valid     <= 1'b1;
                  out_result    <= '0;
                  out_reg_write <= 1'b0;
                  out_exc       <= EXC_TIMEOUT;
               end
            end
            ST_WAIT: begin
               if (dmem_rvalid) begin
                  out_valid     <= 1'b1;
                  out_result    <= load_data;
                  out_reg_write <= op_reg_write_reg;
                  out_exc       <= EXC_NONE;
               end else if (timeout) begin
                  out_valid     <= 1'b1;
                  out_result    <= '0;
                  out_reg_write <= 1'b0;
                  out_exc       <= EXC_TIMEOUT;
               end
            end
            default: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected WB results, a
// negedge monitor pops and compares on every out_valid && out_ready.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_mem_read = 1'b0;
   logic        in_mem_write = 1'b0;
   logic [2:0]  in_funct3 = '0;
   logic [63:0] in_alu_result = '0;
   logic [63:0] in_store_data = '0;
   logic [4:0]  in_rd_addr = '0;
   logic        in_reg_write = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_result;
   logic [4:0]  out_rd_addr;
   logic        out_reg_write;
   logic [1:0]  out_exc;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_be;
   logic        dmem_gnt = 1'b0;
   logic        dmem_rvalid = 1'b0;
   logic [63:0] dmem_rdata = '0;

   typedef struct packed {
      logic [63:0] result;
      logic [4:0]  rd;
      logic        rw;
      logic [1:0]  exc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   txn = 0;

   mem_stage #(.XLEN(64), .MAX_WAIT(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_mem_read   (in_mem_read),
      .in_mem_write  (in_mem_write),
      .in_funct3     (in_funct3),
      .in_alu_result (in_alu_result),
      .in_store_data (in_store_data),
      .in_rd_addr    (in_rd_addr),
      .in_reg_write  (in_reg_write),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_rd_addr   (out_rd_addr),
      .out_reg_write (out_reg_write),
      .out_exc       (out_exc),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_be       (dmem_be),
      .dmem_gnt      (dmem_gnt),
      .dmem_rvalid   (dmem_rvalid),
      .dmem_rdata    (dmem_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [63:0] result, input logic [4:0] rd, input logic rw,
                       input logic [1:0] exc);
      exp_t e;
      e.result = result;
      e.rd     = rd;
      e.rw     = rw;
      e.exc    = exc;
      exp_q.push_back(e);
   endtask

   task automatic set_op(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] sd,
                         input logic [4:0] rd, input logic rw);
      in_mem_read   = mr;
      in_mem_write  = mw;
      in_funct3     = f3;
      in_alu_result = a;
      in_store_data = sd;
      in_rd_addr    = rd;
      in_reg_write  = rw;
   endtask

   // Present an op and hold it until the transfer edge; returns just after that edge.
   task automatic issue(input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] sd,
                        input logic [4:0] rd, input logic rw);
      set_op(mr, mw, f3, a, sd, rd, rw);
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !in_ready; i++) tick();
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: in_ready got 0, required 1");
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"},   64'(in_ready), 64'd1);
      check({tag, "_out_valid"},  64'(out_valid), 64'd0);
      check({tag, "_out_result"}, out_result, 64'd0);
      check({tag, "_out_misc"},   64'({out_rd_addr, out_reg_write, out_exc}), 64'd0);
      check({tag, "_dmem_ctl"},   64'({dmem_req, dmem_we, dmem_be}), 64'd0);
      check({tag, "_dmem_addr"},  dmem_addr, 64'd0);
      check({tag, "_dmem_wdata"}, dmem_wdata, 64'd0);
   endtask

   // Scoreboard monitor: one line per completed WB transaction.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_txn: got result %h, required no transaction", out_result);
         end else begin
            mon_e = exp_q.pop_front();
            check("txn_result", out_result, mon_e.result);
            check("txn_rd", 64'(out_rd_addr), 64'(mon_e.rd));
            check("txn_reg_write", 64'(out_reg_write), 64'(mon_e.rw));
            check("txn_exc", 64'(out_exc), 64'(mon_e.exc));
            txn++;
            $display("txn %0d: result=%h rd=%0d reg_write=%0b exc=%b",
                     txn, out_result, out_rd_addr, out_reg_write, out_exc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      check_reset_vals("reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 1: non-mem passthrough, three back-to-back
      set_op(1'b0, 1'b0, 3'b000, 64'h1234, 64'd0, 5'd1, 1'b1);
      push(64'h1234, 5'd1, 1'b1, 2'b00);
      in_valid = 1'b1;
      check("t1_in_ready0", 64'(in_ready), 64'd1);
      tick();
      check("t1_out_valid", 64'(out_valid), 64'd1);
      check("t1_no_req", 64'(dmem_req), 64'd0);
      set_op(1'b0, 1'b0, 3'b000, 64'h5678, 64'd0, 5'd2, 1'b1);
      push(64'h5678, 5'd2, 1'b1, 2'b00);
      check("t1_in_ready1", 64'(in_ready), 64'd1);
      tick();
      set_op(1'b0, 1'b0, 3'b000, 64'h9ABC, 64'd0, 5'd3, 1'b0);
      push(64'h9ABC, 5'd3, 1'b0, 2'b00);
      check("t1_in_ready2", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check("t1_out_result3", out_result, 64'h9ABC);

      // 2: LB at 0x1003, gnt after 2 cycles, rvalid one cycle later
      push(64'hFFFF_FFFF_FFFF_FF80, 5'd5, 1'b1, 2'b00);
      issue(1'b1, 1'b0, 3'b000, 64'h1003, 64'd0, 5'd5, 1'b1);
      check("t2_req", 64'(dmem_req), 64'd1);
      check("t2_we", 64'(dmem_we), 64'd0);
      check("t2_addr", dmem_addr, 64'h1000);
      tick();
      tick();
      check("t2_addr_held", dmem_addr, 64'h1000);
      check("t2_req_held", 64'(dmem_req), 64'd1);
      dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      check("t2_wait_no_req", 64'(dmem_req), 64'd0);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 64'h0000_0000_8000_0000;
      tick();
      dmem_rvalid = 1'b0;

      // LBU at the same address, rvalid together with gnt
      push(64'h80, 5'd6, 1'b1, 2'b00);
      issue(1'b1, 1'b0, 3'b100, 64'h1003, 64'd0, 5'd6, 1'b1);
      dmem_gnt    = 1'b1;
      dmem_rvalid = 1'b1;
      tick();
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      check("t2_lbu_valid", 64'(out_valid), 64'd1);

      // 3: SH at 0x2006
      push(64'd0, 5'd8, 1'b0, 2'b00);
      issue(1'b0, 1'b1, 3'b001, 64'h2006, 64'hABCD, 5'd8, 1'b1);
      check("t3_be", 64'(dmem_be), 64'hC0);
      check("t3_wdata", dmem_wdata, 64'hABCD_ABCD_ABCD_ABCD);
      check("t3_we", 64'(dmem_we), 64'd1);
      check("t3_addr", dmem_addr, 64'h2000);
      tick();
      check("t3_req_held", 64'(dmem_req), 64'd1);
      dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      check("t3_req_drop", 64'(dmem_req), 64'd0);

      // 4: misaligned LW, then illegal load size
      push(64'd0, 5'd10, 1'b0, 2'b01);
      issue(1'b1, 1'b0, 3'b010, 64'h3002, 64'd0, 5'd10, 1'b1);
      check("t4_mis_no_req", 64'(dmem_req), 64'd0);
      check("t4_mis_exc", 64'(out_exc), 64'd1);
      push(64'd0, 5'd11, 1'b0, 2'b11);
      issue(1'b1, 1'b0, 3'b111, 64'h4000, 64'd0, 5'd11, 1'b1);
      check("t4_ill_no_req", 64'(dmem_req), 64'd0);
      check("t4_ill_exc", 64'(out_exc), 64'd3);

      // 5: LD with no gnt, MAX_WAIT=4 -> timeout visible on 5th cycle after acceptance
      push(64'd0, 5'd7, 1'b0, 2'b10);
      issue(1'b1, 1'b0, 3'b011, 64'h5000, 64'd0, 5'd7, 1'b1);
      check("t5_req", 64'(dmem_req), 64'd1);
      check("t5_c1_valid", 64'(out_valid), 64'd0);
      for (int k = 2; k <= 4; k++) begin
         tick();
         check($sformatf("t5_c%0d_valid", k), 64'(out_valid), 64'd0);
      end
      tick();
      check("t5_c5_valid", 64'(out_valid), 64'd1);
      check("t5_c5_exc", 64'(out_exc), 64'd2);
      check("t5_c5_req_drop", 64'(dmem_req), 64'd0);
      push(64'hCAFE, 5'd12, 1'b1, 2'b00);
      issue(1'b0, 1'b0, 3'b000, 64'hCAFE, 64'd0, 5'd12, 1'b1);

      // 6: LHU with WB stalled 3 cycles in RESP
      push(64'h8765, 5'd13, 1'b1, 2'b00);
      issue(1'b1, 1'b0, 3'b101, 64'h6002, 64'd0, 5'd13, 1'b1);
      out_ready   = 1'b0;
      dmem_gnt    = 1'b1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 64'h1111_2222_8765_4444;
      tick();
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("t6_stall_valid", 64'(out_valid), 64'd1);
         check("t6_stall_result", out_result, 64'h8765);
         check("t6_stall_rd", 64'(out_rd_addr), 64'd13);
         check("t6_stall_in_ready", 64'(in_ready), 64'd0);
         tick();
      end
      out_ready = 1'b1;
      tick();

      // Reset while in WAIT abandons the op; a late rvalid is ignored
      issue(1'b1, 1'b0, 3'b011, 64'h7000, 64'd0, 5'd9, 1'b1);
      dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      check("t6_in_wait", 64'(dmem_req), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      tick();
      rst_n = 1'b1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 64'hDEAD_BEEF_0000_0001;
      tick();
      dmem_rvalid = 1'b0;
      check("late_rvalid_valid", 64'(out_valid), 64'd0);
      check("late_rvalid_ready", 64'(in_ready), 64'd1);

      push(64'hBEEF, 5'd14, 1'b1, 2'b00);
      issue(1'b0, 1'b0, 3'b000, 64'hBEEF, 64'd0, 5'd14, 1'b1);
      tick();
      tick();
      check("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
